// File: rtl/dmem_responder_pkg.sv
// rvga_types: shared dmem word, byte-mask and responder state types
package rvga_types;
  typedef logic [31:0] rvga_word;
  typedef logic [3:0] rvga_wmask;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} rvga_dmem_state;
endpackage

// File: rtl/dmem_responder_array.sv
// dmem_array: DEPTH_P x 32 byte-writable RAM (clk_i, addr, wdata, wmask, w_v in; combinational rdata out), no reset
module dmem_array
  import rvga_types::*;
#(
  parameter int DEPTH_P = 1024
) (
  input  logic                       clk_i,
  input  logic [$clog2(DEPTH_P)-1:0] addr,
  input  rvga_word                   wdata,
  input  rvga_wmask                  wmask,
  input  logic                       w_v,
  output rvga_word                   rdata
);
  rvga_word mem [DEPTH_P];
  always_ff @(posedge clk_i)
    if (w_v)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: dmem target with wait states; r/w valid, addr, data, wmask in; load data, stall, sticky err out
module dmem_responder
  import rvga_types::*;
#(
  parameter int DEPTH_P   = 1024,
  parameter int LATENCY_P = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmem_r_v_i,
  input  logic        dmem_w_v_i,
  input  logic [31:0] dmem_addr_i,
  input  rvga_word    dmem_data_i,
  input  rvga_wmask   dmem_wmask_i,
  output rvga_word    dmem_data_o,
  output logic        stall_v_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH_P);
  localparam int CW = $clog2(LATENCY_P + 1);
  rvga_dmem_state state, state_n;
  logic [CW-1:0] cnt;
  logic [29:0] waddr_r;
  rvga_word data_r, rdata_r, rdata;
  rvga_wmask wmask_r;
  logic store_r, both_r, req, oor, done, unused_lane;
  assign unused_lane = ^dmem_addr_i[1:0];
  assign req = dmem_r_v_i | dmem_w_v_i;
  assign oor = {2'b0, waddr_r} >= 32'(DEPTH_P);
  assign done = state == WAIT && req && cnt == '0;
  always_comb begin
    state_n = state == IDLE ? (req ? WAIT : IDLE)
            : state == WAIT ? (!req ? IDLE : cnt == '0 ? RESP : WAIT)
            : IDLE;
    stall_v_o = rst_i && (state == WAIT || (state == IDLE && req));
    dmem_data_o = state == RESP && !store_r ? rdata_r : '0;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      waddr_r <= '0;
      data_r  <= '0;
      wmask_r <= '0;
      store_r <= 1'b0;
      both_r  <= 1'b0;
      rdata_r <= '0;
      err_o   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        waddr_r <= dmem_addr_i[31:2];
        data_r  <= dmem_data_i;
        wmask_r <= dmem_wmask_i;
        store_r <= dmem_w_v_i;
        both_r  <= dmem_r_v_i & dmem_w_v_i;
        cnt     <= CW'(LATENCY_P - 1);
      end
      if (state == WAIT && req && cnt != '0) cnt <= cnt - CW'(1);
      if (done) begin
        rdata_r <= oor ? '0 : rdata;
        if (oor || both_r) err_o <= 1'b1;
      end
    end
  dmem_array #(.DEPTH_P(DEPTH_P)) u_array (
    .clk_i (clk_i),
    .addr  (waddr_r[AW-1:0]),
    .wdata (data_r),
    .wmask (wmask_r),
    .w_v   (state == RESP && store_r && !oor),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of two responders (latency 1 and 3)
module tb_dmem_responder;
  import rvga_types::*;
  logic clk = 1'b0, rst = 1'b0;
  logic r1 = 0, w1 = 0, r3 = 0, w3 = 0;
  logic [31:0] a1 = 0, a3 = 0;
  rvga_word d1 = 0, d3 = 0, q1, q3;
  rvga_wmask m1 = 0, m3 = 0;
  logic s1, s3, e1, e3;
  int n = 0, fails = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_P(1024), .LATENCY_P(1)) u1 (
    .clk_i(clk), .rst_i(rst), .dmem_r_v_i(r1), .dmem_w_v_i(w1), .dmem_addr_i(a1),
    .dmem_data_i(d1), .dmem_wmask_i(m1), .dmem_data_o(q1), .stall_v_o(s1), .err_o(e1));
  dmem_responder #(.DEPTH_P(1024), .LATENCY_P(3)) u3 (
    .clk_i(clk), .rst_i(rst), .dmem_r_v_i(r3), .dmem_w_v_i(w3), .dmem_addr_i(a3),
    .dmem_data_i(d3), .dmem_wmask_i(m3), .dmem_data_o(q3), .stall_v_o(s3), .err_o(e3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input bit u, input logic rv, input logic wv, input logic [31:0] a,
                       input rvga_word d, input rvga_wmask m);
    if (u) begin r3 = rv; w3 = wv; a3 = a; d3 = d; m3 = m; end
    else begin r1 = rv; w1 = wv; a1 = a; d1 = d; m1 = m; end
  endtask
  task automatic xact(input bit u, input logic rv, input logic wv, input logic [31:0] a,
                      input rvga_word d, input rvga_wmask m, output rvga_word rd, output int st);
    drive(u, rv, wv, a, d, m);
    st = 0;
    #1;
    while ((u ? s3 : s1) && st < 20) begin
      st++;
      @(posedge clk);
      #2;
    end
    rd = u ? q3 : q1;
    drive(u, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
  endtask
  rvga_word rd;
  int st;
  initial begin
    r1 = 1;
    #1;
    chk("rst_stall", 32'(s1), 32'd0);
    chk("rst_data", q1, 32'd0);
    chk("rst_err", 32'(e1), 32'd0);
    r1 = 0;
    #11 rst = 1;
    @(posedge clk); #2;
    xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, st);
    chk("st_stall_len", 32'(st), 32'd2);
    xact(0, 1, 0, 32'h10, 0, 0, rd, st);
    chk("ld_stall_len", 32'(st), 32'd2);
    chk("ld_data", rd, 32'hDEADBEEF);
    chk("idle_data_zero", q1, 32'd0);
    xact(0, 0, 1, 32'h10, 32'h000000AA, 4'h1, rd, st);
    xact(0, 1, 0, 32'h10, 0, 0, rd, st);
    chk("byte_merge", rd, 32'hDEADBEAA);
    xact(0, 0, 1, 32'h10, 32'h11223344, 4'h0, rd, st);
    chk("mask0_stall_len", 32'(st), 32'd2);
    xact(0, 1, 0, 32'h10, 0, 0, rd, st);
    chk("mask0_nochange", rd, 32'hDEADBEAA);
    chk("err_clean", 32'(e1), 32'd0);
    xact(1, 0, 1, 32'h20, 32'hCAFEF00D, 4'hF, rd, st);
    chk("l3_store_stall", 32'(st), 32'd4);
    chk("l3_store_data0", rd, 32'd0);
    xact(1, 1, 0, 32'h20, 0, 0, rd, st);
    chk("l3_load_stall", 32'(st), 32'd4);
    chk("l3_load_data", rd, 32'hCAFEF00D);
    xact(1, 1, 0, 32'h20, 0, 0, rd, st);
    chk("l3_b2b_stall", 32'(st), 32'd4);
    drive(1, 0, 1, 32'h20, 32'h55555555, 4'hF);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("flush_wait_stall", 32'(s3), 32'd1);
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("flush_idle_stall", 32'(s3), 32'd0);
    xact(1, 1, 0, 32'h20, 0, 0, rd, st);
    chk("flush_nowrite", rd, 32'hCAFEF00D);
    drive(0, 0, 1, 32'h10, 32'h00000000, 4'hF);
    @(posedge clk); #2;
    chk("pre_rst_stall", 32'(s1), 32'd1);
    rst = 0;
    #1;
    chk("midwait_rst_stall", 32'(s1), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1;
    @(posedge clk); #2;
    xact(0, 1, 0, 32'h10, 0, 0, rd, st);
    chk("rst_abort_nowrite", rd, 32'hDEADBEAA);
    xact(0, 0, 1, 32'h0, 32'h0BADF00D, 4'hF, rd, st);
    xact(0, 1, 0, 32'h1000, 0, 0, rd, st);
    chk("oor_load_data", rd, 32'd0);
    chk("oor_err", 32'(e1), 32'd1);
    xact(0, 0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, st);
    xact(0, 1, 0, 32'h0, 0, 0, rd, st);
    chk("oor_store_suppressed", rd, 32'h0BADF00D);
    chk("err_sticky", 32'(e1), 32'd1);
    rst = 0;
    #1;
    chk("err_cleared", 32'(e1), 32'd0);
    @(negedge clk) rst = 1;
    @(posedge clk); #2;
    xact(0, 1, 1, 32'h30, 32'h12345678, 4'hF, rd, st);
    chk("both_stall_len", 32'(st), 32'd2);
    chk("both_store_data0", rd, 32'd0);
    chk("both_err", 32'(e1), 32'd1);
    xact(0, 1, 0, 32'h30, 0, 0, rd, st);
    chk("both_written", rd, 32'h12345678);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the pipeline's dmem request interface (r_v/w_v, byte address, store data, byte write mask, load data).
- Holds a word-addressed, byte-writable RAM and inserts a configurable number of wait states.
- Asserts a stall so the memory stage holds its request stable until the response cycle.
- Sits between the memory stage and the top-level stall network.

Parameters:
- DEPTH_P, 1024, number of 32-bit words in the array; power of two, minimum 2.
- LATENCY_P, 1, wait cycles spent in WAIT before the response; minimum 1.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous and active-low.
- dmem_r_v_i  input  1  load request valid.
- dmem_w_v_i  input  1  store request valid.
- dmem_addr_i  input  32  byte address; bits [1:0] ignored (lane selection is done by the slicer via wmask).
- dmem_data_i  input  32  store data, already lane-aligned.
- dmem_wmask_i  input  4  byte-lane write enables; bit n enables byte n.
- dmem_data_o  output  32  load data; valid only in the RESP cycle.
- stall_v_o  output  1  pipeline stall; high while a request is accepted but not yet answered.
- err_o  output  1  sticky error flag.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, counter=0, rdata_r=0, latched address/data/mask=0, err_o=0.
  - stall_v_o=0 and dmem_data_o=0 while in reset.
  - Array contents are not reset. Reset mid-request aborts it with no write.
- Request: req = dmem_r_v_i | dmem_w_v_i.
- States IDLE, WAIT, RESP.
- IDLE:
  - stall_v_o = req (combinational).
  - On req: latch addr, data, wmask and r/w kind; load counter with LATENCY_P-1; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - stall_v_o=1.
  - If req drops (flush): go to IDLE, no access.
  - Else if counter==0: capture array[word index] into rdata_r, go to RESP.
  - Else decrement counter.
- RESP:
  - stall_v_o=0; dmem_data_o = rdata_r for loads, 0 for stores.
  - For stores, write enabled bytes of latched data at the rising edge ending RESP.
  - Go to IDLE unconditionally. The next request is evaluated in IDLE, so back-to-back requests are separated by exactly one RESP cycle.
- Timing: stall_v_o is high for LATENCY_P+1 consecutive cycles, then one RESP cycle.
- Word index = addr[2 +: log2(DEPTH_P)]. Out-of-range when addr[31:2] >= DEPTH_P:
  - load returns 0, store is suppressed, err_o set.
- Both r_v and w_v high: treated as a store, err_o set.
- w_v with wmask=0: completes normally, no bytes change.
- err_o is sticky; cleared only by reset.
- Outside RESP, dmem_data_o=0.
- Read-after-write to the same word on the next request returns the new data, because the write commits before the next WAIT capture.

Decomposition:
- rvga_types (shared package): rvga_word (32b), rvga_wmask (4b), rvga_dmem_state enum {IDLE, WAIT, RESP}.
- One sub-module: dmem_array.
  - Synchronous byte-write RAM: DEPTH_P x 32, ports addr, wdata, wmask, w_v, rdata.
  - Combinational read, no reset.
- The responder holds the FSM, counter, latches, range check and error flag.

Test Plan:
- LATENCY_P=1; after reset, store addr 0x10, data 0xDEADBEEF, wmask 0xF -> stall high for 2 cycles, RESP on cycle 2.
  - Then load 0x10 -> stall for 2 cycles; dmem_data_o=0xDEADBEEF in RESP.
- Store 0x000000AA with wmask 0x1 over word 0x10 -> a following load returns 0xDEADBEAA.
  - A store with wmask 0x0 leaves 0xDEADBEAA.
- LATENCY_P=3; load 0x20 -> stall high exactly 4 cycles, then one RESP cycle with stall 0; the next request is accepted in the following IDLE cycle.
- DEPTH_P=1024; load 0x00001000 -> dmem_data_o=0, err_o=1 and stays 1.
  - A store to 0x00001000 leaves word 0 unchanged.
- Drop r_v in the second WAIT cycle (flush) -> state returns to IDLE, stall 0 next cycle, no write.
  - Assert rst_i=0 mid-WAIT of a store -> stall_v_o=0 immediately, word unchanged after release.
- r_v and w_v both high, addr 0x30, data 0x12345678, wmask 0xF -> word written, err_o=1.
